udp_tx_pkt_buf: RTL



---
 rtl/udp_tx_pkt_buf.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/udp_tx_pkt_buf.sv
// Packet payload buffer ahead of the UDP transmitter; optional second bank with `UDP_TX_BUF_PINGPONG_EN.
// Latency: last byte accepted -> tx_start_en two cycles later; tx_data one cycle after tx_req.
// Backpressure: in_ready drops while no bank is free to fill; drops while a truncated tail is discarded? no, discard keeps in_ready high.
module udp_tx_pkt_buf #(
    parameter int ADDR_W  = 11,
    parameter int MAX_LEN = 1472
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    input  logic        tx_req,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic        trunc
);
    typedef enum logic [1:0] {S_FILL, S_ARM, S_SEND} state_t;

`ifdef UDP_TX_BUF_PINGPONG_EN
    // Bank select toggles on every packet close / every tx_done.
    localparam logic PP     = 1'b1;
    localparam int   MEM_AW = ADDR_W + 1;
`else
    // Single bank: bank selects stay at zero.
    localparam logic PP     = 1'b0;
    localparam int   MEM_AW = ADDR_W;
`endif
    localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

    logic [7:0] mem [0:(2**MEM_AW)-1];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]       len_q, len_d;
    logic              discard_q, discard_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic [1:0][15:0]  blen_q, blen_d;
    logic [15:0]       byte_num_q, byte_num_d;
    logic              start_q, start_d;
    logic [7:0]        tx_data_q;
    logic [MEM_AW-1:0] wr_addr, rd_addr;

    logic accept, wr_en, at_max, close, rd_in_range, rd_hit, nxt_bank;

`ifdef UDP_TX_BUF_PINGPONG_EN
    assign wr_addr = {wr_bank_q, wr_ptr_q};
    assign rd_addr = {rd_bank_q, rd_ptr_q};
`else
    assign wr_addr = wr_ptr_q;
    assign rd_addr = rd_ptr_q;
`endif

    // A bank that is closed and not yet released cannot be written.
    assign in_ready    = !rst && !full_q[wr_bank_q];
    assign accept      = in_valid && in_ready;
    assign wr_en       = accept && !discard_q;
    assign at_max      = (len_q == MAX_LEN16 - 16'd1);
    assign close       = wr_en && (in_last || at_max);
    assign trunc       = wr_en && at_max && !in_last;
    assign nxt_bank    = rd_bank_q ^ PP;
    assign rd_in_range = (16'(rd_ptr_q) < byte_num_q);
    assign rd_hit      = (state_q == S_SEND) && tx_req && !tx_done;

    assign tx_start_en = start_q;
    assign tx_byte_num = byte_num_q;
    assign tx_data     = tx_data_q;
    assign busy        = (state_q != S_FILL) || (|full_q);

    // Fill side: write pointer, length, discard of a truncated tail, bank bookkeeping.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        len_d     = len_q;
        discard_d = discard_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        blen_d    = blen_q;
        // Releasing the sending bank first; a close always targets the other (free) bank.
        if ((state_q == S_SEND) && tx_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (accept && discard_q) begin
            if (in_last) begin
                discard_d = 1'b0;
            end
        end else if (close) begin
            // Pointers restart at close; the bank stays locked until its tx_done.
            full_d[wr_bank_q] = 1'b1;
            blen_d[wr_bank_q] = len_q + 16'd1;
            wr_ptr_d          = '0;
            len_d             = '0;
            wr_bank_d         = wr_bank_q ^ PP;
            discard_d         = trunc;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            len_d    = (len_q == MAX_LEN16) ? len_q : len_q + 16'd1;
        end
    end

    // Transmit side FSM: arm a closed bank, serve requests, release on tx_done.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        rd_bank_d  = rd_bank_q;
        byte_num_d = byte_num_q;
        start_d    = 1'b0;
        unique case (state_q)
            S_FILL: begin
                // full_d includes a close happening this cycle, giving the 2-cycle start latency.
                if (full_d[rd_bank_q]) begin
                    state_d    = S_ARM;
                    byte_num_d = blen_d[rd_bank_q];
                end
            end
            S_ARM: begin
                state_d  = S_SEND;
                start_d  = 1'b1;
                rd_ptr_d = '0;
            end
            S_SEND: begin
                if (tx_done) begin
                    rd_bank_d = nxt_bank;
                    if (full_d[nxt_bank]) begin
                        state_d    = S_ARM;
                        byte_num_d = blen_d[nxt_bank];
                    end else begin
                        state_d = S_FILL;
                    end
                end else if (tx_req && rd_in_range) begin
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            len_q      <= '0;
            discard_q  <= 1'b0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= '0;
            blen_q     <= '0;
            byte_num_q <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            len_q      <= len_d;
            discard_q  <= discard_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            blen_q     <= blen_d;
            byte_num_q <= byte_num_d;
            start_q    <= start_d;
        end
    end

    // Payload RAM write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
    end

    // Synchronous RAM read into the output register; zero once past the packet end.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q <= '0;
        end else if (rd_hit) begin
            tx_data_q <= rd_in_range ? mem[rd_addr] : 8'h00;
        end
    end
endmodule
